mac_result_unpacker: RTL
========================

# mac_result_unpacker

Output-side consumer for the sum-of-squares accumulator.
- Captures each 20-bit accumulated result `f` on the cycle the accumulator asserts `valid_out`.
- Buffers results in a small FIFO.
- Streams each result out as bytes, LSB first, over a valid/ready handshake to a narrow downstream link.
- Never back-pressures the accumulator, which has no stall input; results arriving while the FIFO is full are dropped and flagged.

## Interface
Parameters:
- `DEPTH`, 4 — FIFO depth in 20-bit words; power of two, ≥ 2.
- `W`, 20 — result width; fixed at 20 for this revision.

Ports:
- `clk` input 1 — single clock; all state updates on posedge.
- `reset` input 1 — asynchronous, active-high reset.
- `f_in` input 20 — accumulator result; connects to accumulator `f`.
- `valid_in` input 1 — connects to accumulator `valid_out`; `f_in` is captured when high.
- `byte_out` output 8 — current output byte.
- `byte_valid` output 1 — `byte_out` is valid.
- `byte_ready` input 1 — downstream accepts `byte_out`.
- `byte_last` output 1 — high with the final byte of a word.
- `count` output `$clog2(DEPTH)+1` — words held in FIFO, not yet loaded into the serializer.
- `full` output 1 — `count == DEPTH`.
- `dropped` output 1 — sticky; set when a result is lost.

## Operation
- **Push:** at a posedge with `valid_in=1` and `full=0`, write `f_in` at the write pointer. `count` increments.
- **Drop:** at a posedge with `valid_in=1` and `full=1`, discard the word and set `dropped`. This applies even if a pop occurs on the same edge.
  - `dropped` is cleared only by `reset`.
- **Pointers:** write/read pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`.
- **Serializer FSM states:** IDLE, B0, B1, B2, plus B3 when checksum is enabled.
  - IDLE: if `count>0`, load the head word into the 20-bit shift register and pop (`count` decrements), then go to B0. Otherwise stay.
  - B0 drives `sh[7:0]`; B1 drives `sh[15:8]`; B2 drives `{4'b0000, sh[19:16]}`.
  - A state advances only on handshake (`byte_valid && byte_ready`). With no handshake, the state and `byte_out` hold stable.
  - Final byte state, on handshake: if `count>0`, load and pop the next word and go directly to B0 (no idle bubble). Otherwise go to IDLE.
- **Simultaneous push and pop:** `count` is unchanged; data integrity is preserved.
- **Output qualifiers:**
  - `byte_valid=1` in every state except IDLE.
  - `byte_last=1` only in the final byte state.
  - `byte_out=0` in IDLE.
- **Reset:** reset asserted mid-operation immediately (asynchronously) forces:
  - FSM to IDLE;
  - pointers and `count` to 0;
  - `byte_out=0`, `byte_valid=0`, `byte_last=0`, `full=0`, `dropped=0`.

  Partially sent and buffered words are discarded.

## Timing
- Result captured at posedge N appears as B0 on `byte_out` with `byte_valid=1` after posedge N+1, provided the FSM was IDLE.
- Throughput with `byte_ready` held high: one byte per cycle.
  - 3 cycles per word; 4 cycles per word with checksum enabled.
  - Sustained accumulator output faster than one word per 3 cycles eventually fills the FIFO.
- `count`, `full`, and `dropped` are registered; they reflect an edge's push/pop in the cycle after that edge.
- `byte_ready` is sampled only at posedge and may toggle freely between edges.

## Configuration
- Macro: `UNPACK_CHECKSUM_EN`.
- **Defined:** the FSM adds state B3 after B2.
  - B3 drives `byte_out = B0 ^ B1 ^ B2`.
  - `byte_last` moves from B2 to B3.
  - Word cost is 4 bytes.
- **Undefined:** there is no B3; the word ends at B2 with `byte_last`.

## Test plan
1. **Basic order.** Reset, then push 441 (0x001B9) with `byte_ready=1`. Required: `byte_out` sequence B9, 01, 00, with `byte_last` on 00. With checksum enabled, the sequence is B9, 01, 00, B8, with `byte_last` on B8.
2. **Accumulator link.** Drive the accumulator with `a`=21, 36 (valid), then 64 (valid, after gaps), and connect it to this block. Required output words:
   - 441 → C9/… is not expected; 441 emits B9, 01, 00;
   - 1737 emits C9, 06, 00;
   - 5833 emits C9, 16, 00;
   - `dropped=0` throughout.
3. **Back-pressure.** Hold `byte_ready=0` for 10 cycles in B1. Required: `byte_out` stays 01 and `byte_valid` stays 1; 01 completes on the first cycle `byte_ready=1`.
4. **Overflow.** With `DEPTH=4` and `byte_ready=0`, push 6 words 1..6. Required:
   - word 1 is in the serializer; FIFO holds 2..5; `full=1`;
   - word 6 is dropped and `dropped=1`;
   - after releasing `byte_ready`, the output is 1..5 in order; `dropped` stays 1.
5. **Width and back-to-back.** Push 0xFFFFF twice, then 0x00000, with `byte_ready=1`. Required:
   - output FF, FF, 0F, FF, FF, 0F, 00, 00, 00;
   - no cycle with `byte_valid=0` between words.
6. **Reset mid-word.** Assert `reset` during B1 with 2 words buffered. Required: `byte_valid`, `count`, and `dropped` go to 0 immediately. After release, a new push of 0x12345 yields 45, 23, 01.

Source files
------------

// File: rtl/mac_result_unpacker_if.sv
// Byte-stream link between mac_result_unpacker (master) and the narrow
// downstream consumer (slave). One byte per valid/ready handshake;
// byte_last marks the final byte of each 20-bit result.
interface mac_result_unpacker_if;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;
  logic       byte_last;

  modport master (
    output byte_out,
    output byte_valid,
    output byte_last,
    input  byte_ready
  );

  modport slave (
    input  byte_out,
    input  byte_valid,
    input  byte_last,
    output byte_ready
  );
endinterface

// File: rtl/mac_result_unpacker.sv
// mac_result_unpacker: captures 20-bit accumulator results into a small FIFO
// and streams each one out LSB-first as bytes over a valid/ready link.
// The accumulator cannot stall, so a result arriving while the FIFO is full
// is discarded and the sticky 'dropped' flag is raised.
//
// Optional feature: define UNPACK_CHECKSUM_EN to append a fourth byte per
// word holding the XOR of the three data bytes (byte_last moves to it).
module mac_result_unpacker #(
  parameter int DEPTH = 4,   // FIFO depth in words, power of two, >= 2
  parameter int W     = 20   // result width, fixed at 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [W-1:0]             f_in,
  input  logic                     valid_in,
  mac_result_unpacker_if.master    link,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     dropped
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_B0,
    S_B1,
    S_B2,
    S_B3
  } state_t;

  // FIFO storage and bookkeeping
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          dropped_q, dropped_d;

  // Serializer
  state_t        state_q, state_d;
  logic [W-1:0]  sh_q, sh_d;

  logic          push, pop, drop, hs, full_c;
  logic [7:0]    byte_out_c;
  logic          byte_valid_c, byte_last_c;

  assign full_c = (count_q == DEPTH_C);
  assign push   = valid_in && !full_c;
  // A full FIFO drops the incoming word even if a pop frees a slot on the
  // same edge: the decision uses the pre-edge occupancy.
  assign drop   = valid_in && full_c;
  assign hs     = byte_valid_c && link.byte_ready;

  // Output byte selection, decoded purely from the serializer state.
  // NOTE: every signal written in a combinational block gets a default at the
  // top, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    byte_out_c   = 8'h00;
    byte_valid_c = 1'b0;
    byte_last_c  = 1'b0;
    case (state_q)
      S_B0: begin
        byte_out_c   = sh_q[7:0];
        byte_valid_c = 1'b1;
      end
      S_B1: begin
        byte_out_c   = sh_q[15:8];
        byte_valid_c = 1'b1;
      end
      S_B2: begin
        byte_out_c   = {4'b0000, sh_q[19:16]};
        byte_valid_c = 1'b1;
`ifndef UNPACK_CHECKSUM_EN
        byte_last_c  = 1'b1;
`endif
      end
`ifdef UNPACK_CHECKSUM_EN
      S_B3: begin
        byte_out_c   = sh_q[7:0] ^ sh_q[15:8] ^ {4'b0000, sh_q[19:16]};
        byte_valid_c = 1'b1;
        byte_last_c  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Serializer next state: load the head word from IDLE, or straight after
  // the final byte's handshake so back-to-back words have no idle bubble.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    if ((count_q != '0) && ((state_q == S_IDLE) || (hs && byte_last_c))) begin
      pop     = 1'b1;
      sh_d    = mem_q[rd_ptr_q];
      state_d = S_B0;
    end else if (hs) begin
      case (state_q)
        S_B0:    state_d = S_B1;
        S_B1:    state_d = S_B2;
`ifdef UNPACK_CHECKSUM_EN
        S_B2:    state_d = S_B3;
`endif
        default: state_d = S_IDLE;  // final byte taken, nothing queued
      endcase
    end
  end

  // FIFO pointer, occupancy and sticky-drop next-state logic.
  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    dropped_d = dropped_q || drop;
    count_d   = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;  // idle, or push and pop cancel
    endcase
  end

  // State registers; reset abandons any partial word and all buffered words.
  // NOTE: flops are updated with non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sh_q      <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      dropped_q <= dropped_d;
    end
  end

  // FIFO storage write.
  // NOTE: the storage array is deliberately not reset; count_q gates every
  // read, so stale contents are never observed after reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= f_in;
    end
  end

  assign link.byte_out   = byte_out_c;
  assign link.byte_valid = byte_valid_c;
  assign link.byte_last  = byte_last_c;
  assign count           = count_q;
  assign full            = full_c;
  assign dropped         = dropped_q;

endmodule
